// File: rtl/ripple_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the time-multiplexed ripple adder sequencer.
// Holds the FSM encoding, the default slice width and the slice-count helper.
package ripple_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_SLICE = 4;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/ripple_seq_ctrl_slice_add.sv
// SLICE-bit combinational ripple adder built from per-bit full-adder equations.
// Zero latency; no flow control (pure logic between the sequencer's shift registers).
module ripple_slice_add
  import ripple_seq_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] sum,
  output logic             co
);

  always_comb begin
    logic cy;
    cy  = ci;
    sum = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/ripple_seq_ctrl.sv
// Sequencer adding WIDTH-bit operands one SLICE per cycle, LSB first; result NSLICE cycles after accept.
// Result held in DONE until out_ready; no new accept until drained. RIPPLE_SEQ_SUB_EN adds subtract mode.
module ripple_seq_ctrl
  import ripple_seq_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ci,
`ifdef RIPPLE_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             co,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("ripple_seq_ctrl: WIDTH must be a multiple of SLICE");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             co_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [SLICE-1:0] s_slice;
  logic             c_slice;
  logic [WIDTH-1:0] sum_nxt;

`ifdef RIPPLE_SEQ_SUB_EN
  // Two's-complement subtract: invert B and force the initial carry to 1.
  always_comb begin
    b_load = sub ? ~B : B;
    c_load = sub ? 1'b1 : ci;
  end
`else
  always_comb begin
    b_load = B;
    c_load = ci;
  end
`endif

  ripple_slice_add #(.SLICE(SLICE)) u_slice (
    .a   (a_sh[SLICE-1:0]),
    .b   (b_sh[SLICE-1:0]),
    .ci  (carry),
    .sum (s_slice),
    .co  (c_slice)
  );

  // New slice result enters at the top; after NSLICE shifts the LSB slice reaches bit 0.
  if (NSLICE > 1) begin : g_sum_shift
    always_comb sum_nxt = {s_slice, sum_r[WIDTH-1:SLICE]};
  end else begin : g_sum_single
    always_comb sum_nxt = s_slice;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_r       <= '0;
      co_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum_r <= sum_nxt;
          a_sh  <= a_sh >> SLICE;
          b_sh  <= b_sh >> SLICE;
          carry <= c_slice;
          if (cnt == CNT_W'(NSLICE - 1)) begin
            co_r        <= c_slice;
            out_valid_r <= 1'b1;
            cnt         <= '0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = out_valid_r;
  assign SUM       = sum_r;
  assign co        = co_r;

endmodule
